// File: rtl/mul_op_sequencer.sv
// Stream front-end for the add-shift multiplier: queues operand pairs, issues them one at a time,
// waits MUL_LAT cycles and presents the product on a valid/ready port. Optional: MUL_OP_SEQUENCER_CHECK_EN.
module mul_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy,
  output logic               err
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mem_a_q [DEPTH];
  logic [WIDTH-1:0]     mem_a_d [DEPTH];
  logic [WIDTH-1:0]     mem_b_q [DEPTH];
  logic [WIDTH-1:0]     mem_b_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   out_prod_q, out_prod_d;
  logic                 push, pop, capture;

  // Readiness comes from the registered count, so a full FIFO refuses even while ISSUE pops.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = (state_q == ISSUE);
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_a_d[wr_ptr_q] = in_a;
      mem_b_d[wr_ptr_q] = in_b;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ISSUE;
          mul_a_d = mem_a_q[rd_ptr_q];
          mul_b_d = mem_b_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        pop        = 1'b1;
        wait_cnt_d = CNT_W'(MUL_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          capture     = 1'b1;
          out_prod_d  = mul_prod;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
    end
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
  end

`ifdef MUL_OP_SEQUENCER_CHECK_EN
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] ref_prod;

  // mul_a/mul_b are held through WAIT, so they still describe the product being captured.
  assign ref_prod = (2*WIDTH)'(mul_a_q) * (2*WIDTH)'(mul_b_q);

  always_comb begin
    err_d = err_q;
    if (capture && (mul_prod != ref_prod)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
